spi_apb_regfile: RTL and testbench

Second-generation APB register file for the SPI controller. It adds parametrised frame width and chip-select count, TX/RX data FIFOs of parametrised depth, PSLVERR reporting with full address and access checks, W1C status bits and an interrupt output. It sits between the APB interconnect and the SPI shift engine. The engine reads its configuration, pops TX frames and pushes RX frames through this block.

---
 rtl/spi_apb_regfile.sv | 207 ++++++++++++++++++++
 tb/tb_spi_apb_regfile.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_apb_regfile.sv
// APB register file for the SPI controller: configuration registers, TX/RX frame
// FIFOs, W1C status flags and an interrupt, behind a one-wait-state APB slave.
module spi_apb_regfile #(
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter int                        APB_DATA_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] SPI_REG_BASE   = 32'hA0300000,
  parameter int                        FRAME_WIDTH    = 8,
  parameter int                        FIFO_DEPTH     = 4,
  parameter int                        CS_NUM         = 1
) (
  input  logic                        apb_clk_in,
  input  logic                        apb_rstn_in,
  input  logic                        apb_psel_in,
  input  logic                        apb_penable_in,
  input  logic                        apb_write_in,
  input  logic [APB_ADDR_WIDTH-1:0]   apb_addr_in,
  input  logic [APB_DATA_WIDTH-1:0]   apb_wdata_in,
  input  logic [APB_DATA_WIDTH/8-1:0] apb_strb_in,
  output logic [APB_DATA_WIDTH-1:0]   apb_rdata_out,
  output logic                        apb_ready_out,
  output logic                        apb_slverr_out,
  output logic [7:0]                  spi_cr1_out,
  output logic [7:0]                  spi_cr2_out,
  output logic [7:0]                  spi_br_out,
  output logic [CS_NUM-1:0]           cs_sel_out,
  output logic [FRAME_WIDTH-1:0]      tx_data_out,
  output logic                        tx_valid_out,
  input  logic                        tx_ready_in,
  input  logic [FRAME_WIDTH-1:0]      rx_data_in,
  input  logic                        rx_valid_in,
  input  logic                        modf_in,
  input  logic                        spi_busy_in,
  output logic                        irq_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, RESP} state_t;

  state_t                      state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic                        write_q, write_d, strb0_q, strb0_d;
  logic                        ready_q, ready_d, slverr_q, slverr_d;
  logic [7:0]                  cr1_q, cr1_d, br_q, br_d;
  logic [5:0]                  cr2_q, cr2_d;
  logic [CS_NUM-1:0]           csr_q, csr_d;
  logic                        modf_q, modf_d, rxovr_q, rxovr_d, irq_q, irq_d;
  logic [PW-1:0]               tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PW-1:0]               rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0]               tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [FRAME_WIDTH-1:0]      tx_mem [FIFO_DEPTH];
  logic [FRAME_WIDTH-1:0]      rx_mem [FIFO_DEPTH];

  logic                        txe, txf, rxne, rxf, in_win, is_dr, err, access;
  logic                        wr_en, rd_ok, tx_push, tx_pop, rx_pop, rx_push_ok;
  logic                        tx_flush, rx_flush, tx_we, rx_we, rx_ovf;
  logic [7:0]                  off;
  logic [APB_DATA_WIDTH-1:0]   rd_val;
  logic                        unused_bits;

  assign unused_bits = ^{wdata_q, apb_strb_in};

  always_comb begin
    state_d   = state_q;   addr_d    = addr_q;    wdata_d  = wdata_q;
    write_d   = write_q;   strb0_d   = strb0_q;   rdata_d  = rdata_q;
    ready_d   = ready_q;   slverr_d  = slverr_q;  cr1_d    = cr1_q;
    cr2_d     = cr2_q;     br_d      = br_q;      csr_d    = csr_q;
    tx_wptr_d = tx_wptr_q; tx_rptr_d = tx_rptr_q; tx_cnt_d = tx_cnt_q;
    rx_wptr_d = rx_wptr_q; rx_rptr_d = rx_rptr_q; rx_cnt_d = rx_cnt_q;

    txe    = (tx_cnt_q == '0);
    txf    = (tx_cnt_q == CW'(FIFO_DEPTH));
    rxne   = (rx_cnt_q != '0);
    rxf    = (rx_cnt_q == CW'(FIFO_DEPTH));
    off    = addr_q[7:0];
    in_win = (addr_q[APB_ADDR_WIDTH-1:8] == SPI_REG_BASE[APB_ADDR_WIDTH-1:8]);
    is_dr  = (off == 8'h10);
    err    = !in_win || (off > 8'h18) || (off[1:0] != 2'b00) ||
             (write_q && off == 8'h18) || (write_q && is_dr && txf) ||
             (!write_q && is_dr && !rxne);
    access = (state_q == SETUP) && apb_psel_in && apb_penable_in;
    wr_en  = access && !err && write_q && strb0_q;
    rd_ok  = access && !err && !write_q;

    rd_val = '0;
    case (off)
      8'h00: rd_val[7:0] = cr1_q;
      8'h04: rd_val[7:0] = {2'b00, cr2_q};
      8'h08: rd_val[7:0] = br_q;
      8'h0C: rd_val[6:0] = {spi_busy_in, modf_q, rxovr_q, rxf, rxne, txf, txe};
      8'h10: rd_val[FRAME_WIDTH-1:0] = rx_mem[rx_rptr_q];
      8'h14: rd_val[CS_NUM-1:0] = csr_q;
      8'h18: begin
        rd_val[7:0]  = 8'(tx_cnt_q);
        rd_val[15:8] = 8'(rx_cnt_q);
      end
      default: rd_val = '0;
    endcase

    if (wr_en && off == 8'h00) cr1_d = wdata_q[7:0];
    if (wr_en && off == 8'h04) cr2_d = wdata_q[5:0];
    if (wr_en && off == 8'h08) br_d  = wdata_q[7:0] & 8'h77;
    if (wr_en && off == 8'h14) csr_d = wdata_q[CS_NUM-1:0];

    tx_flush = wr_en && (off == 8'h04) && wdata_q[7];
    rx_flush = wr_en && (off == 8'h04) && wdata_q[6];
    tx_push  = wr_en && is_dr;
    tx_pop   = !txe && tx_ready_in;
    rx_pop   = rd_ok && is_dr;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    rx_push_ok = rx_valid_in && (!rxf || rx_pop);
    rx_ovf     = rx_valid_in && rxf && !rx_pop && !rx_flush;
    tx_we      = tx_push && !tx_flush;
    rx_we      = rx_push_ok && !rx_flush;

    if (tx_flush) begin
      tx_wptr_d = '0; tx_rptr_d = '0; tx_cnt_d = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end
    if (rx_flush) begin
      rx_wptr_d = '0; rx_rptr_d = '0; rx_cnt_d = '0;
    end else begin
      if (rx_push_ok) rx_wptr_d = rx_wptr_q + 1'b1;
      if (rx_pop)     rx_rptr_d = rx_rptr_q + 1'b1;
      rx_cnt_d = rx_cnt_q + CW'(rx_push_ok) - CW'(rx_pop);
    end

    // Set beats a same-edge W1C clear.
    modf_d  = modf_in | (modf_q & !(wr_en && off == 8'h0C && wdata_q[5]));
    rxovr_d = rx_ovf  | (rxovr_q & !(wr_en && off == 8'h0C && wdata_q[4]));
    irq_d   = (cr1_q[7] & (rxne | rxovr_q | modf_q)) | (cr1_q[5] & txe);

    case (state_q)
      IDLE: begin
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        if (apb_psel_in && !apb_penable_in) begin
          state_d = SETUP;
          addr_d  = apb_addr_in;
          write_d = apb_write_in;
          wdata_d = apb_wdata_in;
          strb0_d = apb_strb_in[0];
        end else if (apb_psel_in && apb_penable_in) begin
          state_d  = RESP;
          ready_d  = 1'b1;
          slverr_d = 1'b1;
          rdata_d  = '0;
        end
      end
      SETUP: begin
        if (access) begin
          state_d  = RESP;
          ready_d  = 1'b1;
          slverr_d = err;
          rdata_d  = rd_ok ? rd_val : '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        ready_d  = 1'b0;
        slverr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state_q   <= IDLE;  addr_q    <= '0;  wdata_q  <= '0;
      write_q   <= 1'b0;  strb0_q   <= 1'b0; rdata_q <= '0;
      ready_q   <= 1'b0;  slverr_q  <= 1'b0; cr1_q   <= 8'h04;
      cr2_q     <= '0;    br_q      <= '0;   csr_q   <= '1;
      modf_q    <= 1'b0;  rxovr_q   <= 1'b0; irq_q   <= 1'b0;
      tx_wptr_q <= '0;    tx_rptr_q <= '0;   tx_cnt_q <= '0;
      rx_wptr_q <= '0;    rx_rptr_q <= '0;   rx_cnt_q <= '0;
    end else begin
      state_q   <= state_d;   addr_q    <= addr_d;    wdata_q  <= wdata_d;
      write_q   <= write_d;   strb0_q   <= strb0_d;   rdata_q  <= rdata_d;
      ready_q   <= ready_d;   slverr_q  <= slverr_d;  cr1_q    <= cr1_d;
      cr2_q     <= cr2_d;     br_q      <= br_d;      csr_q    <= csr_d;
      modf_q    <= modf_d;    rxovr_q   <= rxovr_d;   irq_q    <= irq_d;
      tx_wptr_q <= tx_wptr_d; tx_rptr_q <= tx_rptr_d; tx_cnt_q <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d; rx_rptr_q <= rx_rptr_d; rx_cnt_q <= rx_cnt_d;
    end
  end

  always_ff @(posedge apb_clk_in) begin
    if (tx_we) tx_mem[tx_wptr_q] <= wdata_q[FRAME_WIDTH-1:0];
    if (rx_we) rx_mem[rx_wptr_q] <= rx_data_in;
  end

  assign apb_rdata_out  = rdata_q;
  assign apb_ready_out  = ready_q;
  assign apb_slverr_out = slverr_q;
  assign spi_cr1_out    = cr1_q;
  assign spi_cr2_out    = {2'b00, cr2_q};
  assign spi_br_out     = br_q;
  assign cs_sel_out     = csr_q;
  assign tx_data_out    = tx_mem[tx_rptr_q];
  assign tx_valid_out   = !txe;
  assign irq_out        = irq_q;
endmodule

// File: tb/tb_spi_apb_regfile.sv
// Scoreboard bench for spi_apb_regfile: APB expectations and FIFO frames are queued
// at stimulus time and popped when the DUT answers.
module tb_spi_apb_regfile;
  localparam logic [31:0] BASE = 32'hA0300000;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        psel = 0, penable = 0, pwrite = 0;
  logic [31:0] paddr = '0, pwdata = '0, prdata;
  logic [3:0]  pstrb = '0;
  logic        pready, pslverr;
  logic [7:0]  cr1, cr2, br, txd, rxd = '0;
  logic [0:0]  cs;
  logic        txv, txr = 0, rxv = 0, modf = 0, busy = 0, irq;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  typedef struct { logic w; logic [7:0] off; logic [31:0] d; logic [3:0] s; logic [31:0] er; logic ee; } op_t;
  exp_t exp_q[$];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  spi_apb_regfile dut (
    .apb_clk_in(clk), .apb_rstn_in(rstn), .apb_psel_in(psel), .apb_penable_in(penable),
    .apb_write_in(pwrite), .apb_addr_in(paddr), .apb_wdata_in(pwdata), .apb_strb_in(pstrb),
    .apb_rdata_out(prdata), .apb_ready_out(pready), .apb_slverr_out(pslverr),
    .spi_cr1_out(cr1), .spi_cr2_out(cr2), .spi_br_out(br), .cs_sel_out(cs),
    .tx_data_out(txd), .tx_valid_out(txv), .tx_ready_in(txr), .rx_data_in(rxd),
    .rx_valid_in(rxv), .modf_in(modf), .spi_busy_in(busy), .irq_out(irq));

  // Called 1 time unit after a rising edge; returns 1 time unit after the final edge.
  task automatic apb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic mp, output logic [31:0] rd,
                          output logic err, output int waits, output logic [7:0] cr1_r);
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1; modf = mp; waits = 0; rd = '0; err = 0; cr1_r = '0;
    while (!pready) begin
      waits++;
      if (waits > 16) begin
        checks++; failures++;
        $display("FAIL apb_timeout addr=%h no PREADY within 16 cycles", a);
        break;
      end
      @(posedge clk); #1; modf = 0;
    end
    rd = prdata; err = pslverr; cr1_r = cr1;
    @(posedge clk); #1;
    psel = 0; penable = 0; modf = 0;
  endtask

  task automatic run_ops(input string name, input op_t ops[$]);
    logic [31:0] rd; logic er; int wt; logic [7:0] c1; exp_t e;
    foreach (ops[i]) begin
      exp_q.push_back('{rdata: ops[i].er, err: ops[i].ee});
      apb_xfer(ops[i].w, BASE + 32'(ops[i].off), ops[i].d, ops[i].s, 1'b0, rd, er, wt, c1);
      e = exp_q.pop_front();
      checks++;
      if ((!ops[i].w && rd !== e.rdata) || er !== e.err || wt != 1) begin
        failures++;
        $display("FAIL %s op%0d off=%h: rdata=%h slverr=%b waits=%0d, want rdata=%h slverr=%b waits=1",
                 name, i, ops[i].off, rd, er, wt, e.rdata, e.err);
      end else
        $display("%s op%0d %s off=%h rdata=%h slverr=%b", name, i, ops[i].w ? "W" : "R", ops[i].off, rd, er);
      if (ops[i].w && ops[i].off == 8'h00 && ops[i].s[0] && !ops[i].ee) begin
        checks++;
        if (c1 !== ops[i].d[7:0]) begin
          failures++;
          $display("FAIL %s cr1_on_resp: got %h want %h", name, c1, ops[i].d[7:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    op_t ops[$];
    repeat (3) @(posedge clk); #1;
    checks++;
    if (pready !== 0 || pslverr !== 0 || prdata !== 0 || irq !== 0 || txv !== 0) begin
      failures++;
      $display("FAIL reset_apb: ready=%b slverr=%b rdata=%h irq=%b txv=%b, want all 0", pready, pslverr, prdata, irq, txv);
    end
    checks++;
    if (cr1 !== 8'h04 || cr2 !== 8'h00 || br !== 8'h00 || cs !== 1'b1) begin
      failures++;
      $display("FAIL reset_regs: cr1=%h cr2=%h br=%h cs=%b, want 04 00 00 1", cr1, cr2, br, cs);
    end
    rstn = 1;
    @(posedge clk); #1;
    ops = '{'{0, 8'h00, 0, 4'hF, 32'h04, 0}, '{0, 8'h04, 0, 4'hF, 32'h00, 0},
            '{0, 8'h08, 0, 4'hF, 32'h00, 0}, '{0, 8'h0C, 0, 4'hF, 32'h01, 0},
            '{0, 8'h14, 0, 4'hF, 32'h01, 0}, '{0, 8'h18, 0, 4'hF, 32'h00, 0}};
    run_ops("reset_read", ops);
  endtask

  task automatic test_regs();
    op_t ops[$];
    ops = '{'{1, 8'h08, 32'hFF, 4'hF, 0, 0},    '{0, 8'h08, 0, 4'hF, 32'h77, 0},
            '{1, 8'h00, 32'hA5, 4'hF, 0, 0},    '{1, 8'h00, 32'h5A, 4'hE, 0, 0},
            '{0, 8'h00, 0, 4'hF, 32'hA5, 0},    '{1, 8'h00, 32'h00, 4'hF, 0, 0},
            '{1, 8'h04, 32'hFF, 4'hF, 0, 0},    '{0, 8'h04, 0, 4'hF, 32'h3F, 0},
            '{1, 8'h0C, 32'hFFFF, 4'hF, 0, 0},  '{0, 8'h0C, 0, 4'hF, 32'h01, 0}};
    run_ops("regs", ops);
  endtask

  task automatic test_tx_fifo();
    op_t ops[$];
    for (int i = 1; i <= 4; i++) begin
      ops.push_back('{1, 8'h10, 32'(i * 8'h11), 4'hF, 0, 0});
      txq.push_back(8'(i * 8'h11));
    end
    ops.push_back('{0, 8'h0C, 0, 4'hF, 32'h02, 0});
    ops.push_back('{0, 8'h18, 0, 4'hF, 32'h04, 0});
    ops.push_back('{1, 8'h10, 32'h55, 4'hF, 0, 1});
    ops.push_back('{1, 8'h10, 32'h66, 4'hE, 0, 1});
    ops.push_back('{0, 8'h18, 0, 4'hF, 32'h04, 0});
    run_ops("tx_fill", ops);
    txr = 1;
    for (int i = 0; i < 10 && txv; i++) begin
      checks++;
      if (txq.size() == 0 || txd !== txq[0]) begin
        failures++;
        $display("FAIL tx_pop%0d: tx_data=%h, want %h", i, txd, txq.size() ? txq[0] : 8'h00);
      end else $display("tx_pop%0d data=%h", i, txd);
      if (txq.size()) void'(txq.pop_front());
      @(posedge clk); #1;
    end
    txr = 0;
    checks++;
    if (txq.size() != 0 || txv !== 0) begin
      failures++;
      $display("FAIL tx_drain: %0d frames not popped, tx_valid=%b, want 0 and 0", txq.size(), txv);
    end
    ops = '{'{0, 8'h0C, 0, 4'hF, 32'h01, 0}};
    run_ops("tx_empty", ops);
  endtask

  task automatic test_rx_fifo();
    op_t ops[$];
    logic ovr = 0;
    for (int i = 0; i < 5; i++) begin
      rxd = 8'hA0 + 8'(i); rxv = 1;
      if (rxq.size() < 4) rxq.push_back(rxd); else ovr = 1;
      @(posedge clk); #1; rxv = 0;
    end
    ops.push_back('{0, 8'h0C, 0, 4'hF, 32'h0D | (ovr ? 32'h10 : 0), 0});
    ops.push_back('{0, 8'h18, 0, 4'hF, 32'h400, 0});
    for (int i = 0; i < 6; i++) begin
      if (rxq.size()) ops.push_back('{0, 8'h10, 0, 4'hF, 32'(rxq.pop_front()), 0});
      else            ops.push_back('{0, 8'h10, 0, 4'hF, 32'h0, 1});
    end
    ops.push_back('{1, 8'h0C, 32'h10, 4'hF, 0, 0});
    ops.push_back('{0, 8'h0C, 0, 4'hF, 32'h01, 0});
    run_ops("rx_ovr", ops);
    for (int i = 0; i < 2; i++) begin
      rxd = 8'hC0 + 8'(i); rxv = 1;
      @(posedge clk); #1; rxv = 0;
    end
    ops = '{'{0, 8'h18, 0, 4'hF, 32'h200, 0}, '{1, 8'h04, 32'h40, 4'hF, 0, 0},
            '{0, 8'h18, 0, 4'hF, 32'h000, 0}, '{0, 8'h04, 0, 4'hF, 32'h00, 0}};
    run_ops("rx_flush", ops);
  endtask

  task automatic test_addr_err();
    op_t ops[$];
    ops = '{'{1, 8'h00, 32'h11, 4'hF, 0, 0}};
    run_ops("err_prep", ops);
    ops = '{'{1, 8'h02, 32'hFF, 4'hF, 0, 1}, '{1, 8'h1C, 32'hFF, 4'hF, 0, 1},
            '{0, 8'h1C, 0, 4'hF, 32'h0, 1},  '{1, 8'h18, 32'hFF, 4'hF, 0, 1},
            '{0, 8'h03, 0, 4'hF, 32'h0, 1},  '{0, 8'h00, 0, 4'hF, 32'h11, 0}};
    run_ops("addr_err", ops);
    begin
      logic [31:0] rd; logic er; int wt; logic [7:0] c1;
      apb_xfer(1, BASE + 32'h100, 32'hEE, 4'hF, 0, rd, er, wt, c1);
      checks++;
      if (er !== 1 || cr1 !== 8'h11) begin
        failures++;
        $display("FAIL out_of_window: slverr=%b cr1=%h, want 1 and 11", er, cr1);
      end else $display("out_of_window W addr=%h slverr=%b", BASE + 32'h100, er);
    end
  endtask

  task automatic test_abort();
    op_t ops[$];
    psel = 1; penable = 0; pwrite = 1; paddr = BASE; pwdata = 32'h55; pstrb = 4'hF;
    @(posedge clk); #1; psel = 0;
    @(posedge clk); #1;
    checks++;
    if (pready !== 0) begin
      failures++;
      $display("FAIL abort_ready: ready=%b, want 0", pready);
    end
    @(posedge clk); #1;
    psel = 1; penable = 1; pwdata = 32'h66;
    @(posedge clk); #1;
    checks++;
    if (pready !== 1 || pslverr !== 1) begin
      failures++;
      $display("FAIL protocol_violation: ready=%b slverr=%b, want 1 1", pready, pslverr);
    end
    psel = 0; penable = 0;
    @(posedge clk); #1;
    ops = '{'{0, 8'h00, 0, 4'hF, 32'h11, 0}};
    run_ops("abort_check", ops);
  endtask

  task automatic test_irq();
    op_t ops[$];
    logic [31:0] rd; logic er; int wt; logic [7:0] c1;
    ops = '{'{1, 8'h00, 32'h80, 4'hF, 0, 0}};
    run_ops("irq_cfg", ops);
    @(posedge clk); #1;
    modf = 1;
    @(posedge clk); #1; modf = 0;
    checks++;
    if (irq !== 0) begin failures++; $display("FAIL irq_latency: irq=%b one edge after pulse, want 0", irq); end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1) begin failures++; $display("FAIL irq_modf: irq=%b, want 1", irq); end
    apb_xfer(1, BASE + 32'h0C, 32'h20, 4'hF, 1'b1, rd, er, wt, c1);
    ops = '{'{0, 8'h0C, 0, 4'hF, 32'h21, 0}, '{1, 8'h0C, 32'h20, 4'hF, 0, 0},
            '{0, 8'h0C, 0, 4'hF, 32'h01, 0}};
    run_ops("modf_w1c", ops);
    checks++;
    if (irq !== 0) begin failures++; $display("FAIL irq_clear: irq=%b, want 0", irq); end
    ops = '{'{1, 8'h00, 32'h20, 4'hF, 0, 0}};
    run_ops("irq_sptie", ops);
    checks++;
    if (irq !== 1) begin failures++; $display("FAIL irq_txe: irq=%b, want 1", irq); end
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    ops = '{'{1, 8'h14, 32'h0, 4'hF, 0, 0}, '{0, 8'h14, 0, 4'hF, 32'h0, 0},
            '{1, 8'h14, 32'h1, 4'hF, 0, 0}, '{0, 8'h14, 0, 4'hF, 32'h1, 0}};
    run_ops("back_to_back", ops);
    checks++;
    if (cs !== 1'b1) begin failures++; $display("FAIL cs_out: cs=%b, want 1", cs); end
  endtask

  task automatic test_reset_mid_resp();
    op_t ops[$];
    psel = 1; penable = 0; pwrite = 1; paddr = BASE; pwdata = 32'h33; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1;
    @(posedge clk); #1;
    checks++;
    if (pready !== 1) begin failures++; $display("FAIL resp_before_reset: ready=%b, want 1", pready); end
    #2 rstn = 0;
    #1;
    checks++;
    if (pready !== 0 || cr1 !== 8'h04 || irq !== 0) begin
      failures++;
      $display("FAIL reset_mid_resp: ready=%b cr1=%h irq=%b, want 0 04 0", pready, cr1, irq);
    end
    psel = 0; penable = 0;
    @(posedge clk); #1; rstn = 1;
    @(posedge clk); #1;
    ops = '{'{0, 8'h00, 0, 4'hF, 32'h04, 0}, '{0, 8'h0C, 0, 4'hF, 32'h01, 0}};
    run_ops("after_reset", ops);
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx_fifo();
    test_rx_fifo();
    test_addr_err();
    test_abort();
    test_irq();
    test_back_to_back();
    test_reset_mid_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
